// File: rtl/sdram_cmd_ctrl_pkg.sv
// rtl/sdram_cmd_ctrl_pkg.sv - shared SDRAM encodings, timings and mode word (refresh path: SDRAM_REFRESH_EN)
package sdram_cmd_ctrl_pkg;

   typedef enum logic [3:0] {
      W_IDLE   = 4'd0,
      W_ACTIVE = 4'd1,
      W_TRCD   = 4'd2,
      W_WRITE  = 4'd3,
      W_WD     = 4'd4,
      W_TWR    = 4'd5,
      W_READ   = 4'd6,
      W_CL     = 4'd7,
      W_RD     = 4'd8,
      W_PRECH  = 4'd9,
      W_TRP    = 4'd10,
      W_AR     = 4'd11,
      W_TRFC   = 4'd12
   } work_state_t;

   typedef enum logic [2:0] {
      I_WAIT, I_PRE, I_AREF, I_ANOP, I_MRS, I_MRSW, I_DONE
   } init_state_t;

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_RD   = 4'b0101;
   localparam logic [3:0] CMD_WR   = 4'b0100;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_MRS  = 4'b0000;

   localparam int T_RCD      = 1;
   localparam int T_WD       = 1;
   localparam int T_WR       = 2;
   localparam int T_RP       = 1;
   localparam int T_RFC      = 7;
   localparam int T_CL       = 2;
   localparam int REF_PERIOD = 780;
   localparam int INIT_WAIT  = 20000;
   localparam int INIT_AREFS = 8;
   localparam int AREF_GAP   = 7;

   localparam logic [12:0] MODE_WORD = 13'h0030;
   localparam logic [12:0] PRE_ALL   = 13'h0400;

   // Dwell of each access state minus one; states not listed last one cycle.
   function automatic logic [14:0] state_wait(work_state_t s);
      case (s)
         W_TRCD:  return 15'(T_RCD - 1);
         W_WD:    return 15'(T_WD - 1);
         W_TWR:   return 15'(T_WR - 1);
         W_CL:    return 15'(T_CL - 1);
         W_TRP:   return 15'(T_RP - 1);
         W_TRFC:  return 15'(T_RFC - 1);
         default: return 15'd0;
      endcase
   endfunction

endpackage

// File: rtl/sdram_cmd_ctrl_if.sv
// rtl/sdram_cmd_ctrl_if.sv - system-side request/acknowledge bundle
interface sdram_cmd_ctrl_if;
   logic        sys_wr_req;
   logic        sys_rd_req;
   logic [23:0] sys_addr;
   logic        sys_wr_ack;
   logic        sys_rd_ack;

   modport master (output sys_wr_req, sys_rd_req, sys_addr, input sys_wr_ack, sys_rd_ack);
   modport slave  (input sys_wr_req, sys_rd_req, sys_addr, output sys_wr_ack, sys_rd_ack);
endinterface

// File: rtl/sdram_cmd_ctrl_init.sv
// rtl/sdram_cmd_ctrl_init.sv - power-up sequencer: wait, PRE all, 8 AREF, MRS, done
module sdram_init
   import sdram_cmd_ctrl_pkg::*;
(
   input  logic        clk_100m,
   input  logic        rst_n,
   output logic [3:0]  cmd,
   output logic [12:0] addr,
   output logic        init_done
);

   init_state_t state, state_n;
   logic [14:0] cnt, cnt_n;
   logic [2:0]  aref_cnt, aref_cnt_n;

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         state    <= I_WAIT;
         cnt      <= 15'(INIT_WAIT - 1);
         aref_cnt <= 3'd0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         aref_cnt <= aref_cnt_n;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = (cnt != 15'd0) ? cnt - 15'd1 : cnt;
      aref_cnt_n = aref_cnt;
      cmd        = CMD_NOP;
      addr       = 13'd0;
      case (state)
         I_WAIT: if (cnt == 15'd0) state_n = I_PRE;
         I_PRE: begin
            cmd     = CMD_PRE;
            addr    = PRE_ALL;
            state_n = I_AREF;
         end
         I_AREF: begin
            cmd     = CMD_AREF;
            cnt_n   = 15'(AREF_GAP - 1);
            state_n = I_ANOP;
         end
         I_ANOP: begin
            if (cnt == 15'd0) begin
               if (aref_cnt == 3'(INIT_AREFS - 1)) begin
                  state_n = I_MRS;
               end else begin
                  aref_cnt_n = aref_cnt + 3'd1;
                  state_n    = I_AREF;
               end
            end
         end
         I_MRS: begin
            cmd     = CMD_MRS;
            addr    = MODE_WORD;
            state_n = I_MRSW;
         end
         // The first cycle of I_DONE supplies the second post-MRS NOP.
         I_MRSW:  state_n = I_DONE;
         I_DONE:  state_n = I_DONE;
         default: state_n = I_WAIT;
      endcase
   end

   assign init_done = (state == I_DONE);

endmodule

// File: rtl/sdram_cmd_ctrl.sv
// rtl/sdram_cmd_ctrl.sv - single-word SDRAM access FSM with init mux; periodic refresh under SDRAM_REFRESH_EN
module sdram_cmd_ctrl
   import sdram_cmd_ctrl_pkg::*;
(
   input  logic              clk_100m,
   input  logic              rst_n,
   sdram_cmd_ctrl_if.slave   sys,
   output logic              sdram_cke,
   output logic [3:0]        sdram_cmd,
   output logic [1:0]        sdram_ba,
   output logic [12:0]       sdram_addr,
   output logic [3:0]        work_state,
   output logic              init_done
);

   logic [3:0]  init_cmd;
   logic [12:0] init_addr;

   sdram_init u_init (
      .clk_100m  (clk_100m),
      .rst_n     (rst_n),
      .cmd       (init_cmd),
      .addr      (init_addr),
      .init_done (init_done)
   );

   work_state_t state, state_n;
   logic [14:0] cnt;
   logic [23:0] addr_q;
   logic        op_wr;
   logic        timer_done;
   logic [3:0]  acc_cmd;
   logic [1:0]  acc_ba;
   logic [12:0] acc_addr;

   assign timer_done = (cnt == 15'd0);

`ifdef SDRAM_REFRESH_EN
   logic [9:0] ref_cnt;
   logic       refresh_pending;

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         ref_cnt         <= 10'd0;
         refresh_pending <= 1'b0;
      end else if (init_done) begin
         if (ref_cnt == 10'(REF_PERIOD - 1)) begin
            ref_cnt         <= 10'd0;
            refresh_pending <= 1'b1;
         end else begin
            ref_cnt <= ref_cnt + 10'd1;
            if (state == W_AR) refresh_pending <= 1'b0;
         end
      end
   end
`endif

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         sdram_cke <= 1'b0;
         state     <= W_IDLE;
         cnt       <= 15'd0;
         addr_q    <= 24'd0;
         op_wr     <= 1'b0;
      end else begin
         sdram_cke <= 1'b1;
         state     <= state_n;
         if (state_n != state) cnt <= state_wait(state_n);
         else if (!timer_done) cnt <= cnt - 15'd1;
         // Address and direction are captured once so a late request change cannot split an access.
         if (state == W_IDLE && state_n == W_ACTIVE) begin
            addr_q <= sys.sys_addr;
            op_wr  <= sys.sys_wr_req;
         end
      end
   end

   always_comb begin
      state_n = state;
      if (state == W_IDLE) begin
         if (init_done) begin
`ifdef SDRAM_REFRESH_EN
            if (refresh_pending) state_n = W_AR;
            else
`endif
            if (sys.sys_wr_req || sys.sys_rd_req) state_n = W_ACTIVE;
         end
      end else if (timer_done) begin
         case (state)
            W_ACTIVE: state_n = W_TRCD;
            W_TRCD:   state_n = op_wr ? W_WRITE : W_READ;
            W_WRITE:  state_n = W_WD;
            W_WD:     state_n = W_TWR;
            W_TWR:    state_n = W_PRECH;
            W_READ:   state_n = W_CL;
            W_CL:     state_n = W_RD;
            W_RD:     state_n = W_PRECH;
            W_PRECH:  state_n = W_TRP;
            W_AR:     state_n = W_TRFC;
            default:  state_n = W_IDLE;
         endcase
      end
   end

   always_comb begin
      acc_cmd  = CMD_NOP;
      acc_ba   = 2'd0;
      acc_addr = 13'd0;
      case (state)
         W_ACTIVE: begin
            acc_cmd  = CMD_ACT;
            acc_ba   = addr_q[23:22];
            acc_addr = addr_q[21:9];
         end
         W_WRITE, W_READ: begin
            acc_cmd  = (state == W_WRITE) ? CMD_WR : CMD_RD;
            acc_ba   = addr_q[23:22];
            acc_addr = {4'd0, addr_q[8:0]};
         end
         W_PRECH: begin
            acc_cmd  = CMD_PRE;
            acc_ba   = addr_q[23:22];
            acc_addr = PRE_ALL;
         end
         W_AR:    acc_cmd = CMD_AREF;
         default: acc_cmd = CMD_NOP;
      endcase
   end

   assign sdram_cmd      = init_done ? acc_cmd  : init_cmd;
   assign sdram_addr     = init_done ? acc_addr : init_addr;
   assign sdram_ba       = init_done ? acc_ba   : 2'd0;
   assign work_state     = state;
   assign sys.sys_wr_ack = (state == W_WRITE);
   assign sys.sys_rd_ack = (state == W_RD);

endmodule

// File: tb/tb_sdram_cmd_ctrl.sv
// tb/tb_sdram_cmd_ctrl.sv - scoreboard bench for sdram_cmd_ctrl with randomized single-word traffic
module tb_sdram_cmd_ctrl;
   import sdram_cmd_ctrl_pkg::*;

   localparam int C_NOP = 7, C_ACT = 3, C_RD = 5, C_WR = 4, C_PRE = 2, C_AREF = 1, C_MRS = 0;
   localparam int K_ACKW = 16, K_ACKR = 17, K_DONE = 18;

`ifdef SDRAM_REFRESH_EN
   localparam bit REFRESH_ON = 1'b1;
`else
   localparam bit REFRESH_ON = 1'b0;
`endif

   typedef struct {
      int          kind;
      logic [1:0]  ba;
      logic [12:0] addr;
      int          delta;
   } ev_t;

   logic        clk_100m = 1'b0;
   logic        rst_n    = 1'b0;
   logic        sdram_cke;
   logic [3:0]  sdram_cmd;
   logic [1:0]  sdram_ba;
   logic [12:0] sdram_addr;
   logic [3:0]  work_state;
   logic        init_done;

   sdram_cmd_ctrl_if sys ();

   sdram_cmd_ctrl dut (
      .clk_100m   (clk_100m),
      .rst_n      (rst_n),
      .sys        (sys),
      .sdram_cke  (sdram_cke),
      .sdram_cmd  (sdram_cmd),
      .sdram_ba   (sdram_ba),
      .sdram_addr (sdram_addr),
      .work_state (work_state),
      .init_done  (init_done)
   );

   always #5 clk_100m = ~clk_100m;

   ev_t exp_q[$];
   int  checks = 0, errors = 0;
   int  cycle = 0, last_cycle = 0;
   int  post_init_arefs = 0;
   bit  done_prev = 1'b0;
   bit  init_viol = 1'b0;

   function automatic void chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endfunction

   function automatic void push(int kind, logic [1:0] ba, logic [12:0] addr, int delta);
      ev_t e;
      e.kind = kind; e.ba = ba; e.addr = addr; e.delta = delta;
      exp_q.push_back(e);
   endfunction

   // Init expectations: PRE at cycle 20000, AREFs every 8 cycles, MRS, done 2 cycles later.
   function automatic void push_init();
      push(C_PRE, 2'd0, 13'h0400, 20000);
      push(C_AREF, 2'd0, 13'h0, 1);
      for (int i = 1; i < 8; i++) push(C_AREF, 2'd0, 13'h0, 8);
      push(C_MRS, 2'd0, 13'h0030, 8);
      push(K_DONE, 2'd0, 13'h0, 2);
   endfunction

   function automatic void push_access(logic [23:0] a, bit is_wr, int act_delta);
      push(C_ACT, a[23:22], a[21:9], act_delta);
      push(is_wr ? C_WR : C_RD, a[23:22], {4'd0, a[8:0]}, 2);
      push(is_wr ? K_ACKW : K_ACKR, 2'd0, 13'h0, is_wr ? 0 : 3);
      push(C_PRE, 2'd0, 13'h0400, is_wr ? 4 : 1);
   endfunction

   function automatic void observe(int kind);
      ev_t e;
      bit  ok;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d ba=%0d addr=%h at cycle %0d, expected none", kind, sdram_ba, sdram_addr, cycle);
      end else begin
         e  = exp_q.pop_front();
         ok = (kind == e.kind);
         if (e.delta >= 0 && (cycle - last_cycle) != e.delta) ok = 1'b0;
         if (kind == C_ACT && (sdram_ba != e.ba || sdram_addr != e.addr)) ok = 1'b0;
         if ((kind == C_RD || kind == C_WR) &&
             (sdram_ba != e.ba || sdram_addr[8:0] != e.addr[8:0] || sdram_addr[10] != 1'b0)) ok = 1'b0;
         if (kind == C_PRE && sdram_addr[10] != 1'b1) ok = 1'b0;
         if (kind == C_MRS && sdram_addr != e.addr) ok = 1'b0;
         if (!ok) begin
            errors++;
            $display("FAIL event: got kind=%0d ba=%0d addr=%h delta=%0d, expected kind=%0d ba=%0d addr=%h delta=%0d",
                     kind, sdram_ba, sdram_addr, cycle - last_cycle, e.kind, e.ba, e.addr, e.delta);
         end
      end
      last_cycle = cycle;
   endfunction

   always @(posedge clk_100m) begin
      #1;
      if (!rst_n) begin
         cycle      = 0;
         last_cycle = 0;
         done_prev  = 1'b0;
      end else begin
         cycle++;
         if (int'(sdram_cmd) != C_NOP) begin
            if (int'(sdram_cmd) == C_AREF && init_done) begin
               post_init_arefs++;
               chk("aref_from_w_ar", int'(work_state), int'(W_AR));
            end else begin
               observe(int'(sdram_cmd));
            end
         end
         if (sys.sys_wr_ack) observe(K_ACKW);
         if (sys.sys_rd_ack) begin
            observe(K_ACKR);
            chk("rd_ack_in_w_rd", int'(work_state), int'(W_RD));
         end
         if (init_done && !done_prev) observe(K_DONE);
         done_prev = init_done;
         if (!init_done && (work_state != 4'd0 || sys.sys_wr_ack || sys.sys_rd_ack)) init_viol = 1'b1;
      end
   end

   task automatic wait_ack(input bit is_wr, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk_100m);
         if (is_wr ? sys.sys_wr_ack : sys.sys_rd_ack) ok = 1'b1;
      end
   endtask

   task automatic wait_init();
      bit seen = 1'b0;
      for (int i = 0; i < 21000 && !seen; i++) begin
         @(negedge clk_100m);
         if (init_done) seen = 1'b1;
      end
      chk("init_done_seen", int'(seen), 1);
   endtask

   // mode: 0 write, 1 read, 2 write+read together, 3 write with a read that drops early
   task automatic do_access(input int mode, input logic [23:0] a);
      bit ok;
      sys.sys_addr = a;
      if (mode == 1) begin
         push_access(a, 1'b0, -1);
         sys.sys_rd_req = 1'b1;
         wait_ack(1'b0, ok);
         sys.sys_rd_req = 1'b0;
         chk("rd_ack_seen", int'(ok), 1);
      end else begin
         push_access(a, 1'b1, -1);
         if (mode == 2) push_access(a, 1'b0, REFRESH_ON ? -1 : 3);
         sys.sys_wr_req = 1'b1;
         if (mode == 2) sys.sys_rd_req = 1'b1;
         wait_ack(1'b1, ok);
         sys.sys_wr_req = 1'b0;
         chk("wr_ack_seen", int'(ok), 1);
         if (mode == 2) begin
            wait_ack(1'b0, ok);
            sys.sys_rd_req = 1'b0;
            chk("rd_ack_seen", int'(ok), 1);
         end else if (mode == 3) begin
            sys.sys_rd_req = 1'b1;
            repeat (2) @(negedge clk_100m);
            sys.sys_rd_req = 1'b0;
         end
      end
   endtask

   initial begin
      bit ok;
      sys.sys_wr_req = 1'b0;
      sys.sys_rd_req = 1'b0;
      sys.sys_addr   = 24'd0;
      repeat (3) @(negedge clk_100m);
      chk("reset_cke", int'(sdram_cke), 0);
      chk("reset_cmd", int'(sdram_cmd), C_NOP);
      push_init();
      rst_n = 1'b1;
      @(posedge clk_100m);
      #1;
      chk("cke_after_release", int'(sdram_cke), 1);
      wait_init();

      do_access(0, 24'h40_1234);
      do_access(1, 24'h00_0000);
      do_access(2, 24'h9A_BCDE);
      do_access(3, 24'h12_3456);
      for (int n = 0; n < 30; n++) begin
         do_access(int'($urandom_range(0, 3)), 24'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge clk_100m);
      end

      repeat (5000) @(negedge clk_100m);

      // Reset in the middle of a read (W_CL), then a full re-init.
      sys.sys_addr   = 24'($urandom);
      push_access(sys.sys_addr, 1'b0, -1);
      sys.sys_rd_req = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk_100m);
         if (work_state == 4'd7) ok = 1'b1;
      end
      chk("reached_w_cl", int'(ok), 1);
      rst_n          = 1'b0;
      sys.sys_rd_req = 1'b0;
      exp_q.delete();
      #1;
      chk("rst_cke", int'(sdram_cke), 0);
      chk("rst_cmd", int'(sdram_cmd), C_NOP);
      chk("rst_ba", int'(sdram_ba), 0);
      chk("rst_addr", int'(sdram_addr), 0);
      chk("rst_work_state", int'(work_state), 0);
      chk("rst_init_done", int'(init_done), 0);
      chk("rst_acks", int'({sys.sys_wr_ack, sys.sys_rd_ack}), 0);
      repeat (3) @(negedge clk_100m);
      push_init();
      rst_n = 1'b1;
      wait_init();
      do_access(0, 24'($urandom));
      do_access(1, 24'($urandom));

      repeat (30) @(negedge clk_100m);
      chk("queue_drained", exp_q.size(), 0);
      chk("idle_during_init", int'(init_viol), 0);
      if (REFRESH_ON) chk("refreshes_seen", int'(post_init_arefs >= 5), 1);
      else            chk("no_refresh_after_init", post_init_arefs, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
